// File: rtl/video_frame_crc.sv
// Per-frame video signature: CRC-32/MPEG-2 over active pixels plus pixel and line counts.
// Results are latched at each frame boundary and handed off over a valid/ack interface.
module video_frame_crc #(
    parameter int unsigned BPC    = 5,
    parameter int unsigned PIXW   = 24,
    parameter int unsigned LINEW  = 16,
    parameter int unsigned FRAMEW = 16
) (
    input  logic              clk_pix,
    input  logic              rst_pix_n,
    input  logic              en,
    input  logic              disp_de,
    input  logic              disp_frame,
    input  logic [BPC-1:0]    disp_r,
    input  logic [BPC-1:0]    disp_g,
    input  logic [BPC-1:0]    disp_b,
    output logic [31:0]       res_crc,
    output logic [PIXW-1:0]   res_pix,
    output logic [LINEW-1:0]  res_lines,
    output logic [FRAMEW-1:0] res_frame,
    output logic              res_valid,
    input  logic              res_ack,
    output logic              overrun
);

    localparam int unsigned DW      = 3 * BPC;
    localparam logic [31:0] CrcPoly = 32'h04C1_1DB7;
    localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {StSync, StRun} state_e;

    state_e            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [PIXW-1:0]   pix_q, pix_d;
    logic [LINEW-1:0]  line_q, line_d;
    logic              de_prev_q, de_prev_d;
    logic [FRAMEW-1:0] frame_cnt_q, frame_cnt_d;
    logic [31:0]       res_crc_q, res_crc_d;
    logic [PIXW-1:0]   res_pix_q, res_pix_d;
    logic [LINEW-1:0]  res_lines_q, res_lines_d;
    logic [FRAMEW-1:0] res_frame_q, res_frame_d;
    logic              res_valid_q, res_valid_d;
    logic              overrun_q, overrun_d;

    logic              latch;
    logic              restart;
    logic              accumulate;
    logic [31:0]       base_crc;
    logic [PIXW-1:0]   base_pix;
    logic [LINEW-1:0]  base_line;
    logic              base_prev;
    logic [DW-1:0]     pixel;

    assign pixel = {disp_r, disp_g, disp_b};

    // Fold a whole pixel word into the CRC, MSB first, one bit per unrolled stage.
    function automatic logic [31:0] crc_update(input logic [31:0] crc, input logic [DW-1:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < DW; i++) begin
            if (c[31] ^ data[DW-1-i]) begin
                c = {c[30:0], 1'b0} ^ CrcPoly;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    // FSM next state, accumulator update and result latch/handshake.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        res_crc_d   = res_crc_q;
        res_pix_d   = res_pix_q;
        res_lines_d = res_lines_q;
        res_frame_d = res_frame_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;
        latch       = 1'b0;
        restart     = 1'b0;
        accumulate  = 1'b0;

        unique case (state_q)
            StSync: begin
                if (!en) begin
                    restart = 1'b1;
                end else if (disp_frame) begin
                    // Preceding frame was partial: start fresh, latch nothing.
                    state_d    = StRun;
                    restart    = 1'b1;
                    accumulate = 1'b1;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StSync;
                    restart = 1'b1;
                end else if (disp_frame) begin
                    latch      = 1'b1;
                    restart    = 1'b1;
                    accumulate = 1'b1;
                end else begin
                    accumulate = 1'b1;
                end
            end
            default: begin
                state_d = StSync;
                restart = 1'b1;
            end
        endcase

        // A pixel coincident with disp_frame belongs to the new frame, so it folds
        // into freshly initialised accumulators.
        base_crc  = restart ? CrcInit : crc_q;
        base_pix  = restart ? '0 : pix_q;
        base_line = restart ? '0 : line_q;
        base_prev = restart ? 1'b0 : de_prev_q;

        crc_d     = base_crc;
        pix_d     = base_pix;
        line_d    = base_line;
        de_prev_d = base_prev;

        if (accumulate) begin
            de_prev_d = disp_de;
            if (disp_de) begin
                crc_d = crc_update(base_crc, pixel);
                if (!(&base_pix)) begin
                    pix_d = base_pix + PIXW'(1);
                end
                if (!base_prev && !(&base_line)) begin
                    line_d = base_line + LINEW'(1);
                end
            end
        end

        if (latch) begin
            res_crc_d   = crc_q;
            res_pix_d   = pix_q;
            res_lines_d = line_q;
            res_frame_d = frame_cnt_q;
            frame_cnt_d = frame_cnt_q + FRAMEW'(1);
            res_valid_d = 1'b1;
            // An ack in the latch cycle consumes the old result, so no overrun.
            if (res_valid_q && !res_ack) begin
                overrun_d = 1'b1;
            end
        end else if (res_valid_q && res_ack) begin
            res_valid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q     <= StSync;
            crc_q       <= CrcInit;
            pix_q       <= '0;
            line_q      <= '0;
            de_prev_q   <= 1'b0;
            frame_cnt_q <= '0;
            res_crc_q   <= CrcInit;
            res_pix_q   <= '0;
            res_lines_q <= '0;
            res_frame_q <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            de_prev_q   <= de_prev_d;
            frame_cnt_q <= frame_cnt_d;
            res_crc_q   <= res_crc_d;
            res_pix_q   <= res_pix_d;
            res_lines_q <= res_lines_d;
            res_frame_q <= res_frame_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign res_crc   = res_crc_q;
    assign res_pix   = res_pix_q;
    assign res_lines = res_lines_q;
    assign res_frame = res_frame_q;
    assign res_valid = res_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/video_frame_crc.md
# video_frame_crc

Per-frame signature block that sits directly downstream of the chapter display pipeline (the `disp_*` stream that drives the board or SDL output). It runs a CRC-32 over the RGB value of every active pixel and counts active pixels and lines. At each frame boundary it latches these results and presents them on a valid/ack interface, so the Verilator bench and hardware self-test can check whole frames against golden signatures without capturing video.

## Interface
- `BPC`, 5, bits per colour channel of the incoming stream.
- `PIXW`, 24, width of active-pixel counter.
- `LINEW`, 16, width of active-line counter.
- `FRAMEW`, 16, width of frame sequence counter.
- `clk_pix`  in  1  pixel clock; single clock domain.
- `rst_pix_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  capture enable; low forces SYNC state.
- `disp_de`  in  1  data enable, high for active pixels.
- `disp_frame`  in  1  high for one cycle at frame start.
- `disp_r`, `disp_g`, `disp_b`  in  BPC each  pixel colour.
- `res_crc`  out  32  latched CRC of the last complete frame.
- `res_pix`  out  PIXW  latched active-pixel count.
- `res_lines`  out  LINEW  latched active-line count (de rising edges).
- `res_frame`  out  FRAMEW  sequence number of the latched frame.
- `res_valid`  out  1  result available.
- `res_ack`  in  1  consumer accepts the result.
- `overrun`  out  1  sticky: an unacknowledged result was overwritten.

## Operation
- CRC: CRC-32/MPEG-2. Polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR.
- Each active pixel contributes one 3*BPC-bit word {r,g,b}, MSB first. All bits are folded in one cycle by an unrolled serial update.
- States:
  - SYNC: entered at reset or whenever `en`=0. Pixels are ignored and nothing is latched.
  - RUN.
- Transitions:
  - SYNC→RUN on `disp_frame`=1 with `en`=1. Accumulators are initialised and nothing is latched, because the preceding frame was partial.
  - RUN→RUN on `disp_frame`: latch `crc_acc`, `pix_acc` and `line_acc` into the `res_*` outputs, set `res_frame` to the current frame counter, increment the frame counter (it wraps), set `res_valid`, and reinitialise the accumulators.
  - Any state→SYNC on `en`=0. The accumulators are discarded; `res_*`, `res_valid` and `overrun` are kept.
- Accumulation in RUN:
  - `disp_de`=1: update the CRC and increment `pix_acc`.
  - Rising edge of `disp_de`: increment `line_acc`. The previous `de` is registered; that register is cleared on `disp_frame`.
- Counter width: `pix_acc` and `line_acc` saturate at all-ones and do not wrap.
- Handshake:
  - `res_valid` stays high until a cycle with `res_valid`&&`res_ack`. It then clears on the next edge unless a new latch happens in the same cycle.
  - `res_*` outputs are stable while `res_valid`=1 and no new latch occurs.
  - `res_ack` while `res_valid`=0 is ignored.
- Overrun: a latch while `res_valid`=1 and `res_ack`=0 overwrites the results and sets `overrun`. `overrun` clears only on reset.
- Simultaneous events:
  - `disp_frame` and `disp_de` both high in RUN: the pixel belongs to the NEW frame. The latched values exclude it; the new accumulators start from the init value with this pixel folded in, and `pix_acc`=1, `line_acc`=1.
  - Latch and `res_ack` in the same cycle: `res_valid` stays 1 with the new data, and no overrun.

## Timing
- Reset values:
  - Outputs: `res_crc`=0xFFFFFFFF, `res_pix`=0, `res_lines`=0, `res_frame`=0, `res_valid`=0, `overrun`=0.
  - Internal: state=SYNC, frame counter=0, `crc_acc`=0xFFFFFFFF, `pix_acc`=0, `line_acc`=0.
- Latency: results and `res_valid` update on the clock edge that samples `disp_frame`=1, so they are visible the cycle after.
- Throughput: one pixel per clock, no stalls, no backpressure on the video stream.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous). After release the block waits in SYNC for the next `disp_frame`.
- All outputs are registered. The CRC update is the only long combinational path: 15 XOR stages at BPC=5.

## Test plan
- **Empty frames.** Reset, `en`=1, two `disp_frame` pulses 10 cycles apart with no `de`. Required: `res_valid`=1 only after the second pulse, with `res_crc`=0xFFFFFFFF, `res_pix`=0, `res_lines`=0, `res_frame`=0.
- **Full mode-3 frames.** Feed two full 672x384 frames of a constant colour 0x0886 from the display timing model. Required after each frame boundary: `res_pix`=258048, `res_lines`=384, `res_crc` equal to the software MPEG-2 model, `res_frame` incrementing 0 then 1.
- **Pixel coincident with frame start.** Assert `disp_frame` and `disp_de` together in RUN. Required: the latched values exclude that pixel, and the next frame's `res_pix` counts it.
- **Handshake and overrun.** Hold `res_ack`=0 across two latches: `overrun`=1 and the data is from the later frame. Separately, pulse `res_ack` in the same cycle as a latch: `res_valid` stays 1 and `overrun` stays 0.
- **Enable drop.** Drop `en` mid-frame for one cycle, then raise it. Required: no latch at the next `disp_frame` (SYNC→RUN only); the first `res_valid` comes one frame later, with correct counts.
- **Reset mid-frame.** Assert `rst_pix_n`=0 mid-frame with `res_valid`=1. Required: all outputs return to reset values within the same cycle, without a clock edge.
